// File: rtl/demo_sequencer.sv
// Button-driven stimulus sequencer for the demo bus: walks every master through a write and a read
// on its own, then all masters together, handshaking on their ready flags.
module demo_sequencer #(
  parameter  int NUM_MASTERS    = 2,
  parameter  int START_PULSE    = 2,
  parameter  int GAP_CYCLES     = 2,
  parameter  int TIMEOUT_CYCLES = 256,
  localparam int STEPS          = 2*NUM_MASTERS + 2,
  localparam int SW             = $clog2(STEPS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   go_i,
  input  logic                   loop_en_i,
  input  logic [NUM_MASTERS-1:0] ready_i,
  output logic                   start_o,
  output logic [NUM_MASTERS-1:0] mode_o,
  output logic [NUM_MASTERS-1:0] en_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [SW-1:0]          step_idx_o
);

  // One counter serves the start pulse, the gap and the timeout, so size it for the largest.
  localparam int CW       = $clog2(TIMEOUT_CYCLES + START_PULSE + GAP_CYCLES + 1);
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_ASSERT, S_WAIT_DONE, S_GAP, S_FINISH
  } state_e;

  state_e                 state_q, state_d;
  logic                   start_q, start_d;
  logic [NUM_MASTERS-1:0] mode_q, mode_d;
  logic [NUM_MASTERS-1:0] en_q, en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [SW-1:0]          step_q, step_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   seen_q, seen_d;
  logic [NUM_MASTERS-1:0] en_tbl, mode_tbl;
  logic                   all_rdy, any_busy;

  assign all_rdy  = &ready_i;
  assign any_busy = |(en_q & ~ready_i);

  // Steps 2i/2i+1 exercise master i alone; the last two steps drive every master at once.
  always_comb begin
    en_tbl   = '0;
    mode_tbl = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      en_tbl[i]   = (step_q == SW'(2*i)) || (step_q == SW'(2*i+1)) ||
                    (step_q >= SW'(2*NUM_MASTERS));
      mode_tbl[i] = (step_q == SW'(2*i)) || (step_q == SW'(2*NUM_MASTERS));
    end
  end

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    mode_d  = mode_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    step_d  = step_q;
    cnt_d   = cnt_q + CW'(1);
    seen_d  = seen_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (go_i) begin
          state_d = S_WAIT_RDY;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          step_d  = '0;
        end
      end
      S_WAIT_RDY: begin
        if (all_rdy) begin
          state_d = S_ASSERT;
          start_d = 1'b0;
          en_d    = en_tbl;
          mode_d  = mode_tbl;
          cnt_d   = '0;
          seen_d  = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_FINISH;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      S_ASSERT: begin
        if (any_busy) seen_d = 1'b1;
        if (cnt_q == CW'(START_PULSE - 1)) begin
          state_d = S_WAIT_DONE;
          start_d = 1'b1;
          cnt_d   = '0;
        end
      end
      S_WAIT_DONE: begin
        if (seen_q && all_rdy) begin
          state_d = S_GAP;
          seen_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          if (any_busy) seen_d = 1'b1;
          if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_FINISH;
            start_d = 1'b1;
            err_d   = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (cnt_q == CW'(GAP_LAST)) begin
          cnt_d = '0;
          if (step_q == SW'(STEPS - 1)) begin
            if (loop_en_i) begin
              state_d = S_WAIT_RDY;
              step_d  = '0;
            end else begin
              state_d = S_FINISH;
              done_d  = 1'b1;
            end
          end else begin
            state_d = S_WAIT_RDY;
            step_d  = step_q + SW'(1);
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      start_q <= 1'b1;
      mode_q  <= '0;
      en_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      step_q  <= '0;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      mode_q  <= mode_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
    end
  end

  assign start_o    = start_q;
  assign mode_o     = mode_q;
  assign en_o       = en_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign step_idx_o = step_q;

endmodule

// File: tb/tb_demo_sequencer.sv
// Bench for demo_sequencer: behavioural masters answer the start strobe; every start pulse is
// recorded and compared in order against an expected step queue.
module tb_demo_sequencer;
  logic       clk = 1'b0, rst = 1'b1, go = 1'b0, loop_en = 1'b0;
  logic [1:0] ready, mode_o, en_o;
  logic       start_o, busy_o, done_o, err_o;
  logic [2:0] step_o;

  demo_sequencer #(.NUM_MASTERS(2), .START_PULSE(2), .GAP_CYCLES(2), .TIMEOUT_CYCLES(64)) dut (
    .clk_i(clk), .rst_i(rst), .go_i(go), .loop_en_i(loop_en), .ready_i(ready),
    .start_o(start_o), .mode_o(mode_o), .en_o(en_o), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .step_idx_o(step_o)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Masters: ready drops 2 cycles after start falls, rises 10 cycles later.
  logic [1:0] rdy_m = 2'b11;
  int         mcnt [2];
  logic       start_prev = 1'b1;
  logic       stuck1 = 1'b0, nodrop0 = 1'b0;
  assign ready = rdy_m & ~{stuck1, 1'b0};

  always @(posedge clk) begin
    start_prev <= start_o;
    if (rst) begin
      rdy_m   <= 2'b11;
      mcnt[0] <= 0;
      mcnt[1] <= 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (mcnt[i] == 0) begin
          if (start_prev && !start_o && en_o[i] && !(i == 0 && nodrop0)) mcnt[i] <= 2;
        end else if (mcnt[i] == 2) begin
          rdy_m[i] <= 1'b0;
          mcnt[i]  <= 3;
        end else if (mcnt[i] == 12) begin
          rdy_m[i] <= 1'b1;
          mcnt[i]  <= 0;
        end else begin
          mcnt[i] <= mcnt[i] + 1;
        end
      end
    end
  end

  typedef struct {
    logic [1:0] en;
    logic [1:0] mode;
    logic [2:0] step;
    int         len;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];
  int   lowcnt = 0, donecnt = 0;

  // Each completed start pulse is recorded with the controls it carried and its low length.
  always @(negedge clk) begin
    if (start_o === 1'b0) lowcnt <= lowcnt + 1;
    else if (lowcnt != 0) begin
      obs_q.push_back('{en_o, mode_o, step_o, lowcnt});
      lowcnt <= 0;
    end
    if (done_o === 1'b1) donecnt <= donecnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic rec_t exp_step(input int s);
    rec_t r;
    case (s)
      0: r = '{2'b01, 2'b01, 3'd0, 2};
      1: r = '{2'b01, 2'b00, 3'd1, 2};
      2: r = '{2'b10, 2'b10, 3'd2, 2};
      3: r = '{2'b10, 2'b00, 3'd3, 2};
      4: r = '{2'b11, 2'b11, 3'd4, 2};
      default: r = '{2'b11, 2'b00, 3'd5, 2};
    endcase
    return r;
  endfunction

  task automatic push_pass;
    for (int s = 0; s < 6; s++) exp_q.push_back(exp_step(s));
  endtask

  task automatic wait_done(input int maxc, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < maxc) begin
      tick;
      n++;
      if (done_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_obs(input int cnt, input int maxc, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      if (obs_q.size() >= cnt) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    bit ok;
    rst = 1'b1;
    repeat (3) tick;
    checks++;
    if ({start_o, busy_o, done_o, err_o} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_ctl: got start/busy/done/err=%b want 1000", {start_o, busy_o, done_o, err_o});
    end
    checks++;
    if ({en_o, mode_o, step_o} !== 7'd0) begin
      failures++;
      $display("FAIL reset_vec: got en=%b mode=%b step=%0d want 00/00/0", en_o, mode_o, step_o);
    end
    rst = 1'b0;
    tick;
    go = 1'b1;
    tick;
    go = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (step_o == 3'd3 && start_o == 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL reset_reach_step3: got no start in step 3 want start low in step 3");
    end
    rst = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    checks++;
    if ({start_o, en_o, mode_o, busy_o, step_o, err_o} !== {1'b1, 2'b00, 2'b00, 1'b0, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid: got start=%b en=%b mode=%b busy=%b step=%0d err=%b want 1/00/00/0/0/0",
               start_o, en_o, mode_o, busy_o, step_o, err_o);
    end
    repeat (20) tick;
    checks++;
    if ({busy_o, start_o} !== 2'b01) begin
      failures++;
      $display("FAIL reset_stays_idle: got busy=%b start=%b want 0/1", busy_o, start_o);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_sequence;
    int n, d0;
    bit ok;
    rec_t e, o;
    obs_q.delete();
    exp_q.delete();
    push_pass();
    loop_en = 1'b0;
    d0 = donecnt;
    go = 1'b1;
    tick;
    go = 1'b0;
    checks++;
    if (busy_o !== 1'b1) begin
      failures++;
      $display("FAIL seq_busy_rise: got busy=%b want 1", busy_o);
    end
    wait_done(600, n, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL seq_done: got no done within 600 cycles want done pulse");
    end
    checks++;
    if ({busy_o, err_o} !== 2'b10) begin
      failures++;
      $display("FAIL seq_at_done: got busy=%b err=%b want 1/0", busy_o, err_o);
    end
    tick;
    checks++;
    if ({busy_o, done_o} !== 2'b00) begin
      failures++;
      $display("FAIL seq_after_done: got busy=%b done=%b want 0/0", busy_o, done_o);
    end
    repeat (3) tick;
    checks++;
    if (donecnt - d0 !== 1) begin
      failures++;
      $display("FAIL seq_done_count: got %0d want 1", donecnt - d0);
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL seq_pulse_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.en !== e.en || o.mode !== e.mode || o.step !== e.step || o.len !== e.len) begin
        failures++;
        $display("FAIL seq_step: got en=%b mode=%b step=%0d len=%0d want en=%b mode=%b step=%0d len=%0d",
                 o.en, o.mode, o.step, o.len, e.en, e.mode, e.step, e.len);
      end
    end
  endtask

  task automatic test_rdy_timeout;
    int n, d0;
    bit ok;
    obs_q.delete();
    exp_q.delete();
    stuck1 = 1'b1;
    d0 = donecnt;
    go = 1'b1;
    tick;
    go = 1'b0;
    wait_done(200, n, ok);
    checks++;
    if (!ok || n < 64 || n > 65) begin
      failures++;
      $display("FAIL rdy_to_latency: got ok=%0d cycles=%0d want done after 64 cycles", ok, n);
    end
    checks++;
    if ({err_o, start_o, step_o} !== {1'b1, 1'b1, 3'd0}) begin
      failures++;
      $display("FAIL rdy_to_state: got err=%b start=%b step=%0d want 1/1/0", err_o, start_o, step_o);
    end
    tick;
    checks++;
    if (busy_o !== 1'b0 || err_o !== 1'b1) begin
      failures++;
      $display("FAIL rdy_to_after: got busy=%b err=%b want 0/1", busy_o, err_o);
    end
    stuck1 = 1'b0;
    repeat (2) tick;
    checks++;
    if (obs_q.size() !== 0 || lowcnt !== 0 || donecnt - d0 !== 1) begin
      failures++;
      $display("FAIL rdy_to_nostart: got pulses=%0d done=%0d want 0/1", obs_q.size(), donecnt - d0);
    end
  endtask

  task automatic test_done_timeout;
    int n;
    bit ok;
    rec_t e, o;
    obs_q.delete();
    exp_q.delete();
    exp_q.push_back(exp_step(0));
    nodrop0 = 1'b1;
    go = 1'b1;
    tick;
    go = 1'b0;
    wait_done(300, n, ok);
    checks++;
    if (!ok || {err_o, step_o} !== {1'b1, 3'd0}) begin
      failures++;
      $display("FAIL done_to_state: got ok=%0d err=%b step=%0d want 1/1/0", ok, err_o, step_o);
    end
    tick;
    checks++;
    if ({start_o, busy_o} !== 2'b10) begin
      failures++;
      $display("FAIL done_to_after: got start=%b busy=%b want 1/0", start_o, busy_o);
    end
    nodrop0 = 1'b0;
    repeat (2) tick;
    checks++;
    if (obs_q.size() !== 1) begin
      failures++;
      $display("FAIL done_to_pulses: got %0d want 1", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.en !== e.en || o.mode !== e.mode || o.step !== e.step || o.len !== e.len) begin
        failures++;
        $display("FAIL done_to_step: got en=%b mode=%b step=%0d len=%0d want en=%b mode=%b step=%0d len=%0d",
                 o.en, o.mode, o.step, o.len, e.en, e.mode, e.step, e.len);
      end
    end
  endtask

  task automatic test_loop;
    int n, d0;
    bit ok;
    rec_t e, o;
    obs_q.delete();
    exp_q.delete();
    push_pass();
    push_pass();
    d0 = donecnt;
    loop_en = 1'b1;
    go = 1'b1;
    tick;
    go = 1'b0;
    wait_obs(7, 800, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL loop_second_pass: got %0d pulses want at least 7", obs_q.size());
    end
    loop_en = 1'b0;
    wait_done(800, n, ok);
    repeat (3) tick;
    checks++;
    if (!ok || donecnt - d0 !== 1 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL loop_done: got ok=%0d done=%0d err=%b want 1/1/0", ok, donecnt - d0, err_o);
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL loop_pulse_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.en !== e.en || o.mode !== e.mode || o.step !== e.step || o.len !== e.len) begin
        failures++;
        $display("FAIL loop_step: got en=%b mode=%b step=%0d len=%0d want en=%b mode=%b step=%0d len=%0d",
                 o.en, o.mode, o.step, o.len, e.en, e.mode, e.step, e.len);
      end
    end
  endtask

  task automatic test_back_to_back;
    int n, d0;
    bit ok;
    rec_t e, o;
    obs_q.delete();
    exp_q.delete();
    push_pass();
    d0 = donecnt;
    go = 1'b1;
    tick;
    go = 1'b0;
    wait_obs(2, 200, ok);
    go = 1'b1;
    repeat (3) tick;
    go = 1'b0;
    wait_done(600, n, ok);
    repeat (6) tick;
    checks++;
    if (!ok || donecnt - d0 !== 1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done: got ok=%0d done=%0d busy=%b want 1/1/0", ok, donecnt - d0, busy_o);
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL b2b_pulse_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.en !== e.en || o.mode !== e.mode || o.step !== e.step || o.len !== e.len) begin
        failures++;
        $display("FAIL b2b_step: got en=%b mode=%b step=%0d len=%0d want en=%b mode=%b step=%0d len=%0d",
                 o.en, o.mode, o.step, o.len, e.en, e.mode, e.step, e.len);
      end
    end
  endtask

  task automatic test_go_during_finish;
    int n, d0;
    bit ok;
    rec_t e, o;
    obs_q.delete();
    exp_q.delete();
    push_pass();
    d0 = donecnt;
    stuck1 = 1'b1;
    go = 1'b1;
    tick;
    go = 1'b0;
    wait_done(200, n, ok);
    checks++;
    if (!ok || err_o !== 1'b1) begin
      failures++;
      $display("FAIL gofin_timeout: got ok=%0d err=%b want 1/1", ok, err_o);
    end
    go = 1'b1;
    tick;
    checks++;
    if ({busy_o, err_o} !== 2'b01) begin
      failures++;
      $display("FAIL gofin_ignored: got busy=%b err=%b want 0/1", busy_o, err_o);
    end
    tick;
    go = 1'b0;
    stuck1 = 1'b0;
    checks++;
    if ({busy_o, err_o} !== 2'b10) begin
      failures++;
      $display("FAIL gofin_accept: got busy=%b err=%b want 1/0", busy_o, err_o);
    end
    wait_done(600, n, ok);
    repeat (3) tick;
    checks++;
    if (!ok || donecnt - d0 !== 2 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL gofin_done: got ok=%0d done=%0d err=%b want 1/2/0", ok, donecnt - d0, err_o);
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL gofin_pulse_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.en !== e.en || o.mode !== e.mode || o.step !== e.step || o.len !== e.len) begin
        failures++;
        $display("FAIL gofin_step: got en=%b mode=%b step=%0d len=%0d want en=%b mode=%b step=%0d len=%0d",
                 o.en, o.mode, o.step, o.len, e.en, e.mode, e.step, e.len);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_rdy_timeout();
    test_done_timeout();
    test_loop();
    test_back_to_back();
    test_go_during_finish();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
